bootrom_arbiter: RTL

- Shares the single-port, 1-cycle-latency boot ROM between two requesters: m0 (instruction fetch) and m1 (data load).
- Decodes each request address against the ROM window and checks alignment.
- Sequences the ROM read and returns data through a valid/ready response channel.
- Sits between the core's fetch/LSU ports and the bootrom instance.

---
 rtl/bootrom_arbiter_if.sv | 33 +++
 rtl/bootrom_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bootrom_arbiter_if.sv
// Request/response bundle between one requester (fetch or load port) and the boot ROM arbiter.
// The master side issues addressed reads; the slave side answers with data and an access-fault flag.
interface bootrom_arbiter_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            resp_err;

  modport master (
    output req_valid,
    output req_addr,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_err
  );
endinterface

// File: rtl/bootrom_arbiter.sv
// Shares a single-port, 1-cycle-latency boot ROM between a fetch port (m0) and a load port (m1).
// Round-robin arbitration, window/alignment decode, one transaction in flight at a time.
module bootrom_arbiter #(
  parameter int unsigned      XLEN            = 64,
  parameter int unsigned      BROM_SIZE_BYTES = 4096,
  parameter logic [XLEN-1:0]  BROM_BASE       = 64'h0000_1000,
  localparam int unsigned     ADDRWIDTH       = $clog2(BROM_SIZE_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bootrom_arbiter_if.slave      m0_io,
  bootrom_arbiter_if.slave      m1_io,
  output logic [ADDRWIDTH-1:0]  rom_addr_o,
  input  logic [XLEN-1:0]       rom_rdata_i
);

  localparam int unsigned     ALIGN_BITS  = $clog2(XLEN / 8);
  localparam logic [XLEN-1:0] WINDOW_SIZE = XLEN'(BROM_SIZE_BYTES);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapt,
    StResp
  } state_e;

  state_e                   state_q, state_d;
  logic                     owner_q, owner_d;   // 0 = m0, 1 = m1
  logic                     rr_q, rr_d;         // requester favoured on a tie
  logic [ADDRWIDTH-1:0]     rom_addr_q, rom_addr_d;
  logic [1:0][XLEN-1:0]     data_q, data_d;
  logic [1:0]               err_q, err_d;

  logic                     gnt0, gnt1;
  logic                     accept;
  logic                     acc_id;
  logic [XLEN-1:0]          acc_addr;
  logic [XLEN-1:0]          acc_off;
  logic                     in_window;
  logic                     aligned;
  logic                     hit;
  logic                     owner_resp_ready;

  // Grants are only offered in IDLE, so req_ready never depends on the response channel.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      if (m0_io.req_valid && (!m1_io.req_valid || !rr_q)) begin
        gnt0 = 1'b1;
      end else if (m1_io.req_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign accept   = gnt0 | gnt1;
  assign acc_id   = gnt1;
  assign acc_addr = gnt1 ? m1_io.req_addr : m0_io.req_addr;
  assign acc_off  = acc_addr - BROM_BASE;

  // Full-width compare on the offset: addresses below the base wrap to huge offsets and miss,
  // and the upper bound never overflows even for a window placed at the top of the map.
  assign in_window = (acc_addr >= BROM_BASE) && (acc_off < WINDOW_SIZE);
  assign aligned   = (acc_addr[ALIGN_BITS-1:0] == '0);
  assign hit       = in_window && aligned;

  assign owner_resp_ready = owner_q ? m1_io.resp_ready : m0_io.resp_ready;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    rom_addr_d = rom_addr_q;
    data_d     = data_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = acc_id;
          rr_d    = ~acc_id;
          if (hit) begin
            rom_addr_d = acc_off[ADDRWIDTH-1:0];
            state_d    = StIssue;
          end else begin
            data_d[acc_id] = '0;
            err_d[acc_id]  = 1'b1;
            state_d        = StResp;
          end
        end
      end
      StIssue: begin
        state_d = StCapt;
      end
      StCapt: begin
        data_d[owner_q] = rom_rdata_i;
        err_d[owner_q]  = 1'b0;
        state_d         = StResp;
      end
      StResp: begin
        if (owner_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      rom_addr_q <= '0;
      data_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      rom_addr_q <= rom_addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign m0_io.req_ready  = gnt0;
  assign m1_io.req_ready  = gnt1;
  assign m0_io.resp_valid = (state_q == StResp) && !owner_q;
  assign m1_io.resp_valid = (state_q == StResp) && owner_q;
  assign m0_io.resp_data  = data_q[0];
  assign m1_io.resp_data  = data_q[1];
  assign m0_io.resp_err   = err_q[0];
  assign m1_io.resp_err   = err_q[1];
  assign rom_addr_o       = rom_addr_q;

endmodule
